// File: rtl/debouncer_hyst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : debouncer_hyst                                                    |
// | Multi-channel hysteretic debouncer with shared sample tick, rise/fall      |
// | pulses. Optional input synchronizer enabled by macro DEBOUNCER_SYNC_EN.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module debouncer_hyst #(
   parameter int WIDTH          = 1,
   parameter int SAMPLE_CNT_MAX = 62500,
   parameter int PULSE_CNT_MAX  = 200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] glitchy_signal,
   output logic [WIDTH-1:0] debounced_signal,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
);

   localparam int                    c_SAMPLE_W    = $clog2(SAMPLE_CNT_MAX);
   localparam int                    c_INT_W       = $clog2(PULSE_CNT_MAX + 1);
   localparam logic [c_SAMPLE_W-1:0] c_SAMPLE_LAST = c_SAMPLE_W'(SAMPLE_CNT_MAX - 1);
   localparam logic [c_INT_W-1:0]    c_INT_MAX     = c_INT_W'(PULSE_CNT_MAX);

   logic [c_SAMPLE_W-1:0] r_sample_cnt;
   logic                  w_tick;
   logic [WIDTH-1:0]      w_sample;

   assign w_tick = (r_sample_cnt == c_SAMPLE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sample_cnt <= '0;
      end else if (w_tick) begin
         r_sample_cnt <= '0;
      end else begin
         r_sample_cnt <= r_sample_cnt + 1'b1;
      end
   end

`ifdef DEBOUNCER_SYNC_EN
   logic [WIDTH-1:0] r_sync_meta;
   logic [WIDTH-1:0] r_sync_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync_meta <= '0;
         r_sync_out  <= '0;
      end else begin
         r_sync_meta <= glitchy_signal;
         r_sync_out  <= r_sync_meta;
      end
   end

   assign w_sample = r_sync_out;
`else
   assign w_sample = glitchy_signal;
`endif

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
         logic [c_INT_W-1:0] r_cnt;
         logic [c_INT_W-1:0] w_cnt_next;
         logic               r_deb;
         logic               r_rise;
         logic               r_fall;

         // Saturating up/down integrator; the ends never wrap.
         always_comb begin
            w_cnt_next = r_cnt;
            if (w_sample[gi] && (r_cnt != c_INT_MAX)) begin
               w_cnt_next = r_cnt + 1'b1;
            end else if (!w_sample[gi] && (r_cnt != '0)) begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end

         // Output only moves at the extremes, giving the hysteresis band.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt  <= '0;
               r_deb  <= 1'b0;
               r_rise <= 1'b0;
               r_fall <= 1'b0;
            end else begin
               r_rise <= 1'b0;
               r_fall <= 1'b0;
               if (w_tick) begin
                  r_cnt <= w_cnt_next;
                  if (w_cnt_next == c_INT_MAX) begin
                     r_deb  <= 1'b1;
                     r_rise <= !r_deb;
                  end else if (w_cnt_next == '0) begin
                     r_deb  <= 1'b0;
                     r_fall <= r_deb;
                  end
               end
            end
         end

         assign debounced_signal[gi] = r_deb;
         assign rise_pulse[gi]       = r_rise;
         assign fall_pulse[gi]       = r_fall;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debouncer_hyst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_debouncer_hyst                                                 |
// | Self-checking bench for debouncer_hyst (WIDTH=2, 10-cycle tick, 4 levels). |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_debouncer_hyst;

   localparam int WIDTH = 2;
   localparam int SCM   = 10;
   localparam int PCM   = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] glitchy_signal = '0;
   logic [WIDTH-1:0] debounced_signal;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;

   always #5 clk = ~clk;

   debouncer_hyst #(
      .WIDTH          (WIDTH),
      .SAMPLE_CNT_MAX (SCM),
      .PULSE_CNT_MAX  (PCM)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .glitchy_signal   (glitchy_signal),
      .debounced_signal (debounced_signal),
      .rise_pulse       (rise_pulse),
      .fall_pulse       (fall_pulse)
   );

   typedef struct {
      logic [1:0] in;
      logic [1:0] deb;
      logic [1:0] rise;
      logic [1:0] fall;
   } tick_rec_t;

   typedef struct {
      int         cyc;
      logic [5:0] exp;
   } sb_t;

   sb_t        sb_q[$];
   sb_t        mon_e;
   tick_rec_t  tbl[$];
   int         n_cmp   = 0;
   int         n_fail  = 0;
   int         cyc_cnt = 0;
   logic [1:0] exp_deb = 2'b00;

   // Cycle index since reset release: posedge k makes cyc_cnt == k.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc_cnt <= 0;
      else        cyc_cnt <= cyc_cnt + 1;
   end

   task automatic chk(input string name, input int cyc, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0b required=%0b", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
         mon_e = sb_q.pop_front();
         if (mon_e.cyc < cyc_cnt)
            chk("stale_entry", mon_e.cyc, 32'(cyc_cnt), 32'(mon_e.cyc));
         else
            chk("outputs{deb,rise,fall}", cyc_cnt,
                32'({debounced_signal, rise_pulse, fall_pulse}), 32'(mon_e.exp));
      end
      if ((rise_pulse & fall_pulse) != '0)
         chk("rise_fall_exclusive", cyc_cnt, 32'(rise_pulse & fall_pulse), 32'd0);
   end

   // Called at a negedge: drive one cycle and expect outputs after the next posedge.
   task automatic cycle(input logic [1:0] in, input logic [1:0] deb,
                        input logic [1:0] rise, input logic [1:0] fall);
      sb_t e;
      glitchy_signal = in;
      e.cyc = cyc_cnt + 1;
      e.exp = {deb, rise, fall};
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic tick(input tick_rec_t r);
      for (int k = 1; k < SCM; k++) cycle(r.in, exp_deb, 2'b00, 2'b00);
      cycle(r.in, r.deb, r.rise, r.fall);
      exp_deb = r.deb;
   endtask

   task automatic add(input int n, input logic [1:0] in, input logic [1:0] deb,
                      input logic [1:0] rise, input logic [1:0] fall);
      tick_rec_t r;
      r.in = in; r.deb = deb; r.rise = rise; r.fall = fall;
      for (int k = 0; k < n; k++) tbl.push_back(r);
   endtask

   task automatic run_tbl();
      for (int k = 0; k < tbl.size(); k++) tick(tbl[k]);
      tbl.delete();
   endtask

   task automatic reset_cycles(input int n);
      rst_n = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("reset_hold", k, 32'({debounced_signal, rise_pulse, fall_pulse}), 32'd0);
      end
      rst_n   = 1'b1;
      exp_deb = 2'b00;
   endtask

   initial begin
      glitchy_signal = 2'b00;
      reset_cycles(3);
`ifdef DEBOUNCER_SYNC_EN
      // Input rises just after posedge 9: sync delay pushes the rise to posedge 50.
      for (int k = 1; k <= 9; k++)  cycle(2'b00, 2'b00, 2'b00, 2'b00);
      for (int k = 10; k <= 49; k++) cycle(2'b01, 2'b00, 2'b00, 2'b00);
      cycle(2'b01, 2'b01, 2'b01, 2'b00);
      cycle(2'b01, 2'b01, 2'b00, 2'b00);
      glitchy_signal = 2'b00;
      reset_cycles(2);
      // High by posedge 8 still reaches the tick at posedge 10.
      for (int k = 1; k <= 7; k++)  cycle(2'b00, 2'b00, 2'b00, 2'b00);
      for (int k = 8; k <= 39; k++) cycle(2'b01, 2'b00, 2'b00, 2'b00);
      cycle(2'b01, 2'b01, 2'b01, 2'b00);
      cycle(2'b01, 2'b01, 2'b00, 2'b00);
`else
      // Clean press ch0, press ch1, hysteresis, releases, bottom saturation.
      add(3, 2'b01, 2'b00, 2'b00, 2'b00);
      add(1, 2'b01, 2'b01, 2'b01, 2'b00);
      add(3, 2'b11, 2'b01, 2'b00, 2'b00);
      add(1, 2'b11, 2'b11, 2'b10, 2'b00);
      for (int k = 0; k < 5; k++) begin
         add(1, 2'b01, 2'b11, 2'b00, 2'b00);
         add(1, 2'b11, 2'b11, 2'b00, 2'b00);
      end
      add(3, 2'b01, 2'b11, 2'b00, 2'b00);
      add(1, 2'b01, 2'b01, 2'b00, 2'b10);
      add(1, 2'b01, 2'b01, 2'b00, 2'b00);
      add(3, 2'b00, 2'b01, 2'b00, 2'b00);
      add(1, 2'b00, 2'b00, 2'b00, 2'b01);
      add(1, 2'b00, 2'b00, 2'b00, 2'b00);
      run_tbl();

      // Glitch rejection: toggling, short press, long release, then full press.
      for (int k = 0; k < SCM; k++)
         cycle((k % 2 == 0) ? 2'b01 : 2'b00, 2'b00, 2'b00, 2'b00);
      add(3, 2'b01, 2'b00, 2'b00, 2'b00);
      add(6, 2'b00, 2'b00, 2'b00, 2'b00);
      add(3, 2'b01, 2'b00, 2'b00, 2'b00);
      add(1, 2'b01, 2'b01, 2'b01, 2'b00);
      add(3, 2'b11, 2'b01, 2'b00, 2'b00);
      add(1, 2'b11, 2'b11, 2'b10, 2'b00);
      run_tbl();

      // Asynchronous reset between edges with both outputs high.
      for (int k = 0; k < 3; k++) cycle(2'b11, 2'b11, 2'b00, 2'b00);
      #2 rst_n = 1'b0;
      #1 chk("async_clear", cyc_cnt,
             32'({debounced_signal, rise_pulse, fall_pulse}), 32'd0);
      @(negedge clk);
      reset_cycles(2);
      add(PCM - 1, 2'b11, 2'b00, 2'b00, 2'b00);
      add(1, 2'b11, 2'b11, 2'b11, 2'b00);
      run_tbl();
      cycle(2'b11, 2'b11, 2'b00, 2'b00);
`endif
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", cyc_cnt, 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
